// File: rtl/stub_playback_ctrl.sv
// Playback sequencer for the stub-input memories: arms on the GO word, aligns start to BC0,
// and drives the shared read enable/address plus per-event framing, done and sync_err flags.
module stub_playback_ctrl #(
   parameter logic [31:0] GO_PATTERN = 32'hDEADBEEF,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned EVT_LEN    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       go_word,
   input  logic              bc0,
   input  logic              abort,
   input  logic [4:0]        num_events,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              evt_start,
   output logic [4:0]        evt_idx,
   output logic              busy,
   output logic              done,
   output logic              sync_err
);

   typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

   localparam logic [ADDR_W-1:0] PosLast = ADDR_W'(EVT_LEN - 1);

   state_e            state_q, state_d;
   logic              go_hit_q, go_hit_prev_q;
   logic [ADDR_W-1:0] pos_q, pos_d;
   logic [4:0]        n_lat_q, n_lat_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [4:0]        evt_idx_q, evt_idx_d;
   logic              rd_en_q, rd_en_d;
   logic              evt_start_q, evt_start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sync_err_q, sync_err_d;
   logic              go_qual;

   // Two consecutive registered matches filter out single-cycle glitches on the GO word.
   assign go_qual = go_hit_q & go_hit_prev_q;

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      n_lat_d    = n_lat_q;
      rd_addr_d  = rd_addr_q;
      evt_idx_d  = evt_idx_q;
      sync_err_d = sync_err_q;

      unique case (state_q)
         StIdle: begin
            if (go_qual) begin
               state_d    = StArmed;
               sync_err_d = 1'b0;
            end
         end
         StArmed: begin
            if (!go_hit_q) begin
               state_d = StIdle;
            end else if (bc0) begin
               state_d   = StRun;
               pos_d     = '0;
               rd_addr_d = '0;
               evt_idx_d = '0;
               n_lat_d   = num_events;
            end
         end
         StRun: begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (bc0 && (pos_q != '0) && !abort) begin
               sync_err_d = 1'b1;
            end
            if (pos_q == PosLast) begin
               pos_d = '0;
               if ((n_lat_q != 5'd0) && (evt_idx_q == n_lat_q - 5'd1)) begin
                  // Last word of the last event: address and index hold in DONE.
                  state_d   = StDone;
                  rd_addr_d = rd_addr_q;
               end else begin
                  evt_idx_d = evt_idx_q + 5'd1;
               end
            end else begin
               pos_d = pos_q + ADDR_W'(1);
            end
         end
         StDone: begin
            if (!go_hit_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d   = StIdle;
         rd_addr_d = '0;
         evt_idx_d = '0;
      end

      rd_en_d     = (state_d == StRun);
      evt_start_d = (state_d == StRun) && (pos_d == '0);
      busy_d      = (state_d == StArmed) || (state_d == StRun);
      done_d      = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         go_hit_q      <= 1'b0;
         go_hit_prev_q <= 1'b0;
         pos_q         <= '0;
         n_lat_q       <= '0;
         rd_addr_q     <= '0;
         evt_idx_q     <= '0;
         rd_en_q       <= 1'b0;
         evt_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         go_hit_q      <= (go_word == GO_PATTERN);
         go_hit_prev_q <= go_hit_q;
         pos_q         <= pos_d;
         n_lat_q       <= n_lat_d;
         rd_addr_q     <= rd_addr_d;
         evt_idx_q     <= evt_idx_d;
         rd_en_q       <= rd_en_d;
         evt_start_q   <= evt_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign evt_start = evt_start_q;
   assign evt_idx   = evt_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_stub_playback_ctrl.sv
// Bench for stub_playback_ctrl: a queue of expected read beats is filled when a run is started
// and drained by a monitor on every rd_en cycle; control flags are checked inline.
module tb_stub_playback_ctrl;

   localparam logic [31:0] GO = 32'hDEADBEEF;
   localparam int AW = 10;
   localparam int EL = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   go_word = '0;
   logic          bc0 = 1'b0;
   logic          abort = 1'b0;
   logic [4:0]    num_events = '0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          evt_start;
   logic [4:0]    evt_idx;
   logic          busy;
   logic          done;
   logic          sync_err;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          start;
      logic [4:0]    idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   stub_playback_ctrl #(
      .GO_PATTERN(GO),
      .ADDR_W    (AW),
      .EVT_LEN   (EL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .go_word   (go_word),
      .bc0       (bc0),
      .abort     (abort),
      .num_events(num_events),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .evt_start (evt_start),
      .evt_idx   (evt_idx),
      .busy      (busy),
      .done      (done),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] no_go();
      logic [31:0] v;
      do v = $urandom; while (v == GO);
      return v;
   endfunction

   // Expected beat i of a run: address i, new event every EL words, event index i/EL.
   task automatic push_run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         exp_t e;
         e.addr  = AW'(i % (1 << AW));
         e.start = ((i % EL) == 0);
         e.idx   = 5'((i / EL) % 32);
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_rd_en: got rd_en=1 addr=%0d, required rd_en=0", rd_addr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_addr", 32'(rd_addr), 32'(e.addr));
            check("sb_evt_start", 32'(evt_start), 32'(e.start));
            check("sb_evt_idx", 32'(evt_idx), 32'(e.idx));
         end
      end
   end

   task automatic arm();
      go_word = GO;
      tick();
      tick();
      check("arm_busy_before_qual", 32'(busy), 0);
      tick();
      check("arm_busy", 32'(busy), 1);
      check("arm_sync_err_clear", 32'(sync_err), 0);
   endtask

   task automatic drop_go_to_idle();
      go_word = no_go();
      tick();
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
   endtask

   task automatic start_run(input int n, input int cycles);
      num_events = 5'(n);
      push_run(cycles);
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      num_events = 5'($urandom);
   endtask

   task automatic run_full(input int n, input int bc0_delay);
      arm();
      repeat (bc0_delay) tick();
      check("armed_wait_busy", 32'(busy), 1);
      start_run(n, n * EL);
      check("run_busy", 32'(busy), 1);
      repeat (n * EL) tick();
      check("done_flag", 32'(done), 1);
      check("done_rd_en", 32'(rd_en), 0);
      check("done_busy", 32'(busy), 0);
      check("done_rd_addr", 32'(rd_addr), 32'((n * EL - 1) % (1 << AW)));
      check("done_evt_idx", 32'(evt_idx), 32'(n - 1));
      check("done_beats_left", exp_q.size(), 0);
      go_word = no_go();
      tick();
      check("done_hold_one_cycle", 32'(done), 1);
      tick();
      check("done_cleared", 32'(done), 0);
      check("done_to_idle_busy", 32'(busy), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_evt_start", 32'(evt_start), 0);
      check("rst_evt_idx", 32'(evt_idx), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sync_err", 32'(sync_err), 0);
      reset = 1'b1;
      tick();

      // Basic run of three events.
      run_full(3, 0);

      // Single-cycle GO match must not qualify.
      go_word = GO;
      tick();
      go_word = no_go();
      tick();
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      repeat (3) begin
         tick();
         check("glitch_busy", 32'(busy), 0);
      end

      // Misaligned BC0 at pos 17 sets the sticky flag without disturbing the counters.
      arm();
      start_run(2, 2 * EL);
      repeat (17) tick();
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      check("sync_err_set", 32'(sync_err), 1);
      repeat (2 * EL - 18) tick();
      check("sync_done", 32'(done), 1);
      check("sync_err_sticky", 32'(sync_err), 1);
      check("sync_beats_left", exp_q.size(), 0);
      drop_go_to_idle();
      check("sync_err_idle", 32'(sync_err), 1);
      arm();
      drop_go_to_idle();

      // Registered go_hit falls in the same cycle bc0 arrives: IDLE wins.
      arm();
      go_word = no_go();
      tick();
      check("corner_still_armed", 32'(busy), 1);
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      check("corner_busy", 32'(busy), 0);
      check("corner_rd_en", 32'(rd_en), 0);
      tick();
      check("corner_rd_en_later", 32'(rd_en), 0);

      // Abort coincides with the final word.
      arm();
      start_run(1, EL);
      repeat (EL - 1) tick();
      abort = 1'b1;
      go_word = no_go();
      tick();
      abort = 1'b0;
      check("abort_last_done", 32'(done), 0);
      check("abort_last_rd_en", 32'(rd_en), 0);
      check("abort_last_busy", 32'(busy), 0);
      check("abort_last_rd_addr", 32'(rd_addr), 0);
      check("abort_last_evt_idx", 32'(evt_idx), 0);
      check("abort_last_beats_left", exp_q.size(), 0);
      tick();

      // Loop mode: 20 events with address wrap, then abort.
      arm();
      start_run(0, 20 * EL);
      repeat (20 * EL - 1) tick();
      check("loop_evt_idx", 32'(evt_idx), 19);
      check("loop_done", 32'(done), 0);
      check("loop_busy", 32'(busy), 1);
      abort = 1'b1;
      go_word = no_go();
      tick();
      abort = 1'b0;
      check("loop_abort_rd_en", 32'(rd_en), 0);
      check("loop_abort_rd_addr", 32'(rd_addr), 0);
      check("loop_abort_evt_idx", 32'(evt_idx), 0);
      check("loop_beats_left", exp_q.size(), 0);
      tick();

      // Asynchronous reset mid-run at address 40.
      arm();
      start_run(3, 3 * EL);
      repeat (40) tick();
      check("pre_reset_addr", 32'(rd_addr), 40);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_rd_en", 32'(rd_en), 0);
      check("async_rst_rd_addr", 32'(rd_addr), 0);
      check("async_rst_evt_start", 32'(evt_start), 0);
      check("async_rst_evt_idx", 32'(evt_idx), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      exp_q.delete();
      go_word = no_go();
      tick();
      tick();
      reset = 1'b1;
      tick();
      run_full(3, 0);

      // Randomized lengths and BC0 arrival.
      repeat (4) run_full(int'($urandom_range(1, 4)), int'($urandom_range(0, 5)));

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
